fb_port_arbiter: RTL
====================

// Module: fb_port_arbiter
// PURPOSE
// Shares the single-port frame-buffer RAM (8000 x 8 bit, 1 bpp, 320x200) between three requesters:
// VGA line prefetch (P0), EPP host access (P1) and the fill/blit draw engine (P2).
// Grants one access per uclk cycle and registers the winning command onto the RAM port.
// Returns read data to the owner, tagged through a latency pipe. Sits between the RAM and all its users.
// PARAMETERS
// ADDR_W      13   word address width (words 0..7999)
// DATA_W      8    RAM word width
// RD_LAT      2    cycles from grant to rdata valid (1 cmd register + 1 RAM register)
// STARVE_MAX  15   max consecutive P0 grants while P1/P2 wait before a forced yield
// PORTS
// uclk        in   1       system clock, all logic on rising edge
// rst         in   1       asynchronous, active-high reset
// pN_req      in   1       N=0..2: access request, held until granted
// pN_we       in   1       N=0..2: 1=write, 0=read
// pN_addr     in   ADDR_W  N=0..2: word address
// pN_wdata    in   DATA_W  N=0..2: write data (ignored for P0; P0 is read-only)
// pN_gnt      out  1       N=0..2: combinational grant; command accepted this cycle
// pN_rvalid   out  1       N=0..2: read data for this requester valid on rd_data
// rd_data     out  DATA_W  read data, shared by all requesters
// fb_addr     out  ADDR_W  RAM address (registered)
// fb_we       out  1       RAM write enable (registered)
// fb_wdata    out  DATA_W  RAM write data (registered)
// fb_rdata    in   DATA_W  RAM read data (RAM registers it 1 cycle after fb_addr)
// BEHAVIOUR
// - Reset: all pN_gnt/pN_rvalid=0; fb_we=0; fb_addr=0; fb_wdata=0; rd_data=0; rr_ptr=P1; starve_cnt=0; tag pipe cleared.
// - Grant (combinational, at most one per cycle):
//   - P0 wins if p0_req and not forced_yield.
//   - Otherwise P1/P2 round-robin: rr_ptr names the preferred one.
//     After a P1 or P2 grant, rr_ptr moves to the other port.
// - forced_yield = (starve_cnt == STARVE_MAX) && (p1_req || p2_req).
// - starve_cnt: +1 on a P0 grant while p1_req||p2_req; cleared on any P1/P2 grant or when neither waits.
//   Saturates at STARVE_MAX.
// - Out-of-range address (addr >= 8000): grant is given and the request consumed.
//   A write becomes a no-op (fb_we=0). A read returns rvalid with rd_data=0.
// - Cycle T grant -> edge T+1: fb_addr/fb_we/fb_wdata take the winner's command.
//   Idle cycles: fb_we=0, fb_addr holds.
// - Tag pipe: a RD_LAT-deep shift register of {valid, id[1:0], oor}, loaded at T+1.
//   At T+RD_LAT: pN_rvalid=1 for exactly one cycle, with rd_data = fb_rdata (or 0 if oor).
// - Writes produce no rvalid. The RAM does not read during a write cycle.
// - Back-to-back reads from any mix of ports sustain 1 access/cycle; rvalids return in grant order.
// - A requester may drop req only after gnt. Changing addr/we while req=1 and gnt=0 is legal;
//   the value present in the grant cycle is used.
// - Same-address write then read (consecutive grants): the read returns the new data.
// - Reset mid-operation clears the tag pipe; in-flight reads are lost and no rvalid is issued.
//   The cmd register returns to fb_we=0 immediately (async).
// STRUCTURE
// - Shared package fb_pkg: FB_WIDTH=320, FB_HEIGHT=200, FB_WORDS=8000, FB_ADDR_W=13, FB_DATA_W=8,
//   requester ids REQ_VGA=0, REQ_HOST=1, REQ_ENG=2.
// - Sub-module fb_rd_tag_pipe (parameter RD_LAT): tag shift register and rvalid/rd_data decode.
// - Grant logic, rr_ptr, starve_cnt and the cmd register stay in this module.
// TESTING
// 1 Reset, then p1 read addr 5 and p2 read addr 6 held together, RAM[5]=0xA5, RAM[6]=0x3C
//   -> p1_gnt first, p2_gnt next cycle; p1_rvalid with 0xA5 at T+2, p2_rvalid with 0x3C at T+3.
// 2 p0_req, p1_req and p2_req held continuously
//   -> 15 P0 grants, then 1 P1 grant, 15 P0 grants, then 1 P2 grant; pattern repeats.
// 3 p2 write addr 100 data 0x0F, then p1 read addr 100 on the next cycle
//   -> fb_we pulse carries 0x0F; p1_rvalid 2 cycles after its grant with rd_data=0x0F.
// 4 p1 write addr 8000 data 0xFF, then p1 read addr 8000
//   -> both granted; fb_we stays 0; read returns rvalid with rd_data=0x00.
// 5 p0 read stream to addrs 0..39 with no other requests
//   -> 40 consecutive grants; 40 p0_rvalid pulses in address order, no gaps.
// 6 rst asserted 1 cycle after a p1 read grant
//   -> no p1_rvalid ever arrives; fb_we=0 and rr_ptr=P1 after release.

Source files
------------

// File: rtl/fb_pkg.sv
// Frame-buffer geometry, requester ids and the read-tag record.
// Shared by the arbiter, its tag pipe and the port interface.
package fb_pkg;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 200;
  localparam int FB_WORDS  = FB_WIDTH * FB_HEIGHT / 8;
  localparam int FB_ADDR_W = 13;
  localparam int FB_DATA_W = 8;

  typedef enum logic [1:0] {
    REQ_VGA  = 2'd0,
    REQ_HOST = 2'd1,
    REQ_ENG  = 2'd2
  } req_id_t;

  typedef struct packed {
    logic    vld;
    req_id_t id;
    logic    oor;
  } rd_tag_t;

  // Round-robin partner between the two non-VGA requesters.
  function automatic req_id_t other_port(input req_id_t id);
    return (id == REQ_HOST) ? REQ_ENG : REQ_HOST;
  endfunction

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Requester ports and RAM port of the frame-buffer arbiter.
// P0 (VGA prefetch) is read-only, so it carries no write enable or write data.
interface fb_port_arbiter_if
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
) ();

  logic              p0_req;
  logic [ADDR_W-1:0] p0_addr;
  logic              p0_gnt;
  logic              p0_rvalid;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;

  logic              p2_req;
  logic              p2_we;
  logic [ADDR_W-1:0] p2_addr;
  logic [DATA_W-1:0] p2_wdata;
  logic              p2_gnt;
  logic              p2_rvalid;

  logic [DATA_W-1:0] rd_data;

  logic [ADDR_W-1:0] fb_addr;
  logic              fb_we;
  logic [DATA_W-1:0] fb_wdata;
  logic [DATA_W-1:0] fb_rdata;

  modport slave (
    input  p0_req, p0_addr,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  p2_req, p2_we, p2_addr, p2_wdata,
    input  fb_rdata,
    output p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, p2_gnt, p2_rvalid,
    output rd_data, fb_addr, fb_we, fb_wdata
  );

  modport master (
    output p0_req, p0_addr,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output p2_req, p2_we, p2_addr, p2_wdata,
    output fb_rdata,
    input  p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, p2_gnt, p2_rvalid,
    input  rd_data, fb_addr, fb_we, fb_wdata
  );

endinterface

// File: rtl/fb_rd_tag_pipe.sv
// Carries {valid, owner, out-of-range} alongside each read for RD_LAT cycles,
// then steers the RAM's registered read data to its owner (zero for out-of-range reads).
module fb_rd_tag_pipe
  import fb_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int DATA_W = FB_DATA_W
) (
  input  logic              uclk,
  input  logic              rst,
  input  logic              load_vld,
  input  req_id_t           load_id,
  input  logic              load_oor,
  input  logic [DATA_W-1:0] fb_rdata,
  output logic [2:0]        rvalid,
  output logic [DATA_W-1:0] rd_data
);

  rd_tag_t pipe [RD_LAT];
  rd_tag_t head;

  always_ff @(posedge uclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= rd_tag_t'{vld: load_vld, id: load_id, oor: load_oor};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign head = pipe[RD_LAT-1];

  assign rvalid[0] = head.vld && (head.id == REQ_VGA);
  assign rvalid[1] = head.vld && (head.id == REQ_HOST);
  assign rvalid[2] = head.vld && (head.id == REQ_ENG);
  assign rd_data   = (head.vld && !head.oor) ? fb_rdata : '0;

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares the single-port frame-buffer RAM: one combinational grant per uclk, registered onto the RAM port.
// P0 has priority bounded by STARVE_MAX; P1/P2 round-robin; read data returns RD_LAT cycles after grant.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 15
) (
  input  logic             uclk,
  input  logic             rst,
  fb_port_arbiter_if.slave bus
);

  localparam int                SC_W   = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0]   SC_MAX = SC_W'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] WORDS  = ADDR_W'(FB_WORDS);

  req_id_t           rr_ptr;
  logic [SC_W-1:0]   starve_cnt;
  logic              others_wait;
  logic              forced_yield;

  logic              win_vld;
  req_id_t           win_id;
  logic              win_we;
  logic              win_oor;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_we;
  logic [DATA_W-1:0] cmd_wdata;
  logic [2:0]        rvalid;

  assign others_wait  = bus.p1_req || bus.p2_req;
  assign forced_yield = (starve_cnt == SC_MAX) && others_wait;

  always_comb begin
    win_vld   = 1'b0;
    win_id    = REQ_VGA;
    win_we    = 1'b0;
    win_addr  = bus.p0_addr;
    win_wdata = '0;
    if (!rst) begin
      if (bus.p0_req && !forced_yield) begin
        win_vld = 1'b1;
      end else if (bus.p1_req && (rr_ptr == REQ_HOST || !bus.p2_req)) begin
        win_vld   = 1'b1;
        win_id    = REQ_HOST;
        win_we    = bus.p1_we;
        win_addr  = bus.p1_addr;
        win_wdata = bus.p1_wdata;
      end else if (bus.p2_req) begin
        win_vld   = 1'b1;
        win_id    = REQ_ENG;
        win_we    = bus.p2_we;
        win_addr  = bus.p2_addr;
        win_wdata = bus.p2_wdata;
      end
    end
  end

  assign win_oor = (win_addr >= WORDS);

  assign bus.p0_gnt = win_vld && (win_id == REQ_VGA);
  assign bus.p1_gnt = win_vld && (win_id == REQ_HOST);
  assign bus.p2_gnt = win_vld && (win_id == REQ_ENG);

  // The starvation count only advances while someone other than P0 is actually waiting.
  always_ff @(posedge uclk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= REQ_HOST;
      starve_cnt <= '0;
    end else begin
      if (win_vld && win_id != REQ_VGA) begin
        rr_ptr     <= other_port(win_id);
        starve_cnt <= '0;
      end else if (!others_wait) begin
        starve_cnt <= '0;
      end else if (win_vld && starve_cnt != SC_MAX) begin
        starve_cnt <= starve_cnt + SC_W'(1);
      end
    end
  end

  // Out-of-range writes are consumed but never reach the RAM; the address holds when idle.
  always_ff @(posedge uclk or posedge rst) begin
    if (rst) begin
      cmd_addr  <= '0;
      cmd_we    <= 1'b0;
      cmd_wdata <= '0;
    end else begin
      cmd_we <= win_vld && win_we && !win_oor;
      if (win_vld) begin
        cmd_addr  <= win_addr;
        cmd_wdata <= win_wdata;
      end
    end
  end

  assign bus.fb_addr  = cmd_addr;
  assign bus.fb_we    = cmd_we;
  assign bus.fb_wdata = cmd_wdata;

  fb_rd_tag_pipe #(
    .RD_LAT (RD_LAT),
    .DATA_W (DATA_W)
  ) u_tag_pipe (
    .uclk     (uclk),
    .rst      (rst),
    .load_vld (win_vld && !win_we),
    .load_id  (win_id),
    .load_oor (win_oor),
    .fb_rdata (bus.fb_rdata),
    .rvalid   (rvalid),
    .rd_data  (bus.rd_data)
  );

  assign bus.p0_rvalid = rvalid[0];
  assign bus.p1_rvalid = rvalid[1];
  assign bus.p2_rvalid = rvalid[2];

endmodule
